// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin-operated vending controller: credit, vend handshake and change return.
// Optional CREDIT inactivity auto-refund is built only with VEND_TIMEOUT_EN defined.
module vend_controller #(
    parameter int TIMEOUT_CYC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin50,
    input  logic       coin100,
    input  logic       buy,
    input  logic       cancel,
    input  logic [1:0] price_sel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       low_credit,
    output logic [2:0] credit,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CREDIT = 2'b01,
        S_VEND   = 2'b10,
        S_CHANGE = 2'b11
    } state_t;

    state_t     cur_state, nxt_state;
    logic [3:0] in_now, in_q, armed, ev;
    logic [2:0] credit_q, credit_d, cred_c, price;
    logic [3:0] coin_sum;
    logic       disp_d, chg_d, rej_d, low_d;

    // armed stays low until an input is seen low, so a level held through reset never fires
    assign in_now = {cancel, buy, coin100, coin50};
    assign ev     = in_now & ~in_q & armed;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        nxt_state = cur_state;
        credit_d  = credit_q;
        disp_d    = disp_req;
        chg_d     = 1'b0;
        rej_d     = 1'b0;
        low_d     = 1'b0;
        coin_sum  = {1'b0, credit_q} + {2'b00, ev[1], ev[0]};
        cred_c    = credit_q;
        price     = {1'b0, price_sel} + 3'd2;
`ifdef VEND_TIMEOUT_EN
        tmo_d     = '0;
`endif
        // a coin pair that would overflow is refused as a whole with a single pulse
        if (ev[0] || ev[1]) begin
            if ((cur_state == S_IDLE || cur_state == S_CREDIT) && coin_sum <= 4'd6)
                cred_c = coin_sum[2:0];
            else
                rej_d = 1'b1;
        end
        case (cur_state)
            S_IDLE: begin
                credit_d = cred_c;
                if (cred_c != 3'd0)
                    nxt_state = S_CREDIT;
            end
            S_CREDIT: begin
                credit_d = cred_c;
                if (ev[3]) begin
                    nxt_state = S_CHANGE;
                    chg_d     = 1'b1;
                end else if (ev[2]) begin
                    if (cred_c >= price) begin
                        credit_d  = cred_c - price;
                        nxt_state = S_VEND;
                        disp_d    = 1'b1;
                    end else begin
                        low_d = 1'b1;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                // an accepted coin always changes credit, which restarts the count
                else if (cred_c == credit_q) begin
                    if (tmo_q == TMO_LAST) begin
                        nxt_state = S_CHANGE;
                        chg_d     = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`endif
            end
            S_VEND: begin
                if (disp_ack) begin
                    disp_d = 1'b0;
                    if (credit_q != 3'd0) begin
                        nxt_state = S_CHANGE;
                        chg_d     = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                // credit drops as each pulse ends; the last decrement returns to IDLE
                if (change_pulse) begin
                    credit_d = credit_q - 3'd1;
                    if (credit_q == 3'd1)
                        nxt_state = S_IDLE;
                end else begin
                    chg_d = 1'b1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state    <= S_IDLE;
            credit_q     <= 3'd0;
            disp_req     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            low_credit   <= 1'b0;
            in_q         <= 4'd0;
            armed        <= 4'd0;
`ifdef VEND_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            cur_state    <= nxt_state;
            credit_q     <= credit_d;
            disp_req     <= disp_d;
            change_pulse <= chg_d;
            coin_reject  <= rej_d;
            low_credit   <= low_d;
            in_q         <= in_now;
            armed        <= armed | ~in_now;
`ifdef VEND_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign credit = credit_q;
    assign state  = cur_state;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller output events and state.
module tb_vend_controller;

    localparam int K_CHG = 1, K_REJ = 2, K_LOW = 3, K_DISP = 4;

    typedef struct {
        int kind;
        int cr;
        int st;
        int gap;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       coin50 = 1'b0, coin100 = 1'b0, buy = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
    logic [1:0] price_sel = 2'b00;
    logic       disp_req, change_pulse, coin_reject, low_credit;
    logic [2:0] credit;
    logic [1:0] state;

    ev_t sb[$];
    int  tests = 0, fails = 0, cyc = 0, last_cyc = 0;
    logic disp_prev = 1'b0, rej_prev = 1'b0, low_prev = 1'b0;

    always #5 clk = ~clk;

    vend_controller #(.TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst(rst), .coin50(coin50), .coin100(coin100), .buy(buy),
        .cancel(cancel), .price_sel(price_sel), .disp_ack(disp_ack),
        .disp_req(disp_req), .change_pulse(change_pulse), .coin_reject(coin_reject),
        .low_credit(low_credit), .credit(credit), .state(state)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int cr, input int st, input int gap);
        ev_t e;
        e.kind = kind; e.cr = cr; e.st = st; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: kind %0d credit %0d state %0d at cycle %0d, none expected",
                     kind, credit, state, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cr != int'(credit) || e.st != int'(state) ||
                (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
                fails++;
                $display("FAIL event: got kind %0d credit %0d state %0d gap %0d, expected kind %0d credit %0d state %0d gap %0d",
                         kind, credit, state, cyc - last_cyc, e.kind, e.cr, e.st, e.gap);
            end
        end
        last_cyc = cyc;
    endtask

    // monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            if (change_pulse) observe(K_CHG);
            if (coin_reject) observe(K_REJ);
            if (low_credit) observe(K_LOW);
            if (disp_req && !disp_prev) observe(K_DISP);
            if ((coin_reject && rej_prev) || (low_credit && low_prev)) begin
                tests++;
                fails++;
                $display("FAIL pulse_width: coin_reject %0d low_credit %0d high two cycles, required one",
                         coin_reject, low_credit);
            end
        end
        disp_prev = disp_req;
        rej_prev  = coin_reject;
        low_prev  = low_credit;
    end

    // bit0 coin50, bit1 coin100, bit2 buy, bit3 cancel
    task automatic pulse(input int which);
        @(negedge clk);
        coin50 = which[0]; coin100 = which[1]; buy = which[2]; cancel = which[3];
        @(negedge clk);
        coin50 = 1'b0; coin100 = 1'b0; buy = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected events still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("reset_state", state, 0);
        check("reset_credit", credit, 0);
        check("reset_disp", disp_req, 0);
        rst = 1'b0;
        idle(2);

        // exact-price vend, no change
        pulse(2);  check("a_credit_2", credit, 2); check("a_state_credit", state, 1);
        pulse(1);  check("a_credit_3", credit, 3);
        price_sel = 2'b01;
        expect_ev(K_DISP, 0, 2, -1);
        pulse(4);  check("a_credit_0", credit, 0); check("a_disp_req", disp_req, 1);
        ack();     check("a_state_idle", state, 0); check("a_disp_low", disp_req, 0);
        idle(4);   drain(5);

        // credit cap, coin refused during VEND, four change pulses
        pulse(2); pulse(2); pulse(2);
        check("b_credit_6", credit, 6);
        expect_ev(K_REJ, 6, 1, -1);
        pulse(2);  check("b_capped", credit, 6);
        price_sel = 2'b00;
        expect_ev(K_DISP, 4, 2, -1);
        pulse(4);  check("b_state_vend", state, 2);
        expect_ev(K_REJ, 4, 2, -1);
        pulse(1);  check("b_vend_coin_ignored", credit, 4);
        expect_ev(K_CHG, 4, 3, -1);
        expect_ev(K_CHG, 3, 3, 2);
        expect_ev(K_CHG, 2, 3, 2);
        expect_ev(K_CHG, 1, 3, 2);
        ack();     check("b_state_change", state, 3);
        drain(20); idle(2);
        check("b_idle", state, 0); check("b_credit_end", credit, 0);

        // insufficient credit, then cancel refund
        pulse(1);  check("c_credit_1", credit, 1);
        price_sel = 2'b10;
        expect_ev(K_LOW, 1, 1, -1);
        pulse(4);  check("c_state_credit", state, 1); check("c_credit_kept", credit, 1);
        expect_ev(K_CHG, 1, 3, -1);
        pulse(8);  drain(10); idle(2);
        check("c_idle", state, 0);

        // buy in IDLE ignored; buy+cancel together resolves as cancel
        pulse(4);  check("d_buy_idle", state, 0);
        pulse(2);  check("d_credit_2", credit, 2);
        price_sel = 2'b00;
        expect_ev(K_CHG, 2, 3, -1);
        expect_ev(K_CHG, 1, 3, 2);
        pulse(12); check("d_state_change", state, 3);
        drain(10); idle(2);
        check("d_idle", state, 0);

        // simultaneous coins refused at the cap with one pulse
        pulse(2); pulse(2);
        expect_ev(K_REJ, 4, 1, -1);
        pulse(3);  check("f_pair_rejected", credit, 4);
        pulse(2);
        expect_ev(K_REJ, 6, 1, -1);
        pulse(1);  check("f_over_cap", credit, 6);
        for (int i = 6; i >= 1; i--) expect_ev(K_CHG, i, 3, (i == 6) ? -1 : 2);
        pulse(8);  drain(30); idle(2);
        check("f_idle", state, 0);

        // simultaneous coins accepted, then reset mid-CHANGE
        pulse(3);  check("e_credit_3", credit, 3);
        expect_ev(K_CHG, 3, 3, -1);
        pulse(8);  check("e_state_change", state, 3); check("e_credit_change", credit, 3);
        #2 rst = 1'b1;
        #1;
        check("e_rst_state", state, 0);
        check("e_rst_credit", credit, 0);
        check("e_rst_change_pulse", change_pulse, 0);
        check("e_rst_disp", disp_req, 0);
        coin50 = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        check("e_held_coin_no_event", credit, 0);
        check("e_held_coin_state", state, 0);
        coin50 = 1'b0;
        idle(1);
        pulse(1);  check("e_credit_after_rearm", credit, 1);
        expect_ev(K_CHG, 1, 3, -1);
        pulse(8);  drain(10); idle(2);
        check("e_idle", state, 0);

`ifdef VEND_TIMEOUT_EN
        pulse(1);
        expect_ev(K_CHG, 1, 3, -1);
        idle(9);   check("t_still_credit", state, 1);
        idle(1);   check("t_timeout_change", state, 3);
        drain(10); idle(2);
        check("t_idle", state, 0);
`else
        pulse(1);
        idle(30);  check("t_no_timeout", state, 1);
        expect_ev(K_CHG, 1, 3, -1);
        pulse(8);  drain(10); idle(2);
        check("t_idle", state, 0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 200, meaning CREDIT-state inactivity cycles before auto-refund (used only with VEND_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port coin50, input, 1, level input whose rising edge inserts 50 units.
REQ-005 The block SHALL have port coin100, input, 1, level input whose rising edge inserts 100 units.
REQ-006 The block SHALL have port buy, input, 1, level input whose rising edge requests a purchase.
REQ-007 The block SHALL have port cancel, input, 1, level input whose rising edge requests a full refund.
REQ-008 The block SHALL have port price_sel, input, 2, item price: 00=100, 01=150, 10=200, 11=250.
REQ-009 The block SHALL have port disp_ack, input, 1, dispenser acknowledge.
REQ-010 The block SHALL have port disp_req, output, 1, dispenser request.
REQ-011 The block SHALL have port change_pulse, output, 1, one-cycle pulse per 50 units returned.
REQ-012 The block SHALL have port coin_reject, output, 1, one-cycle pulse when a coin is refused.
REQ-013 The block SHALL have port low_credit, output, 1, one-cycle pulse when buy is refused for insufficient credit.
REQ-014 The block SHALL have port credit, output, 3, current credit in 50-unit steps (0..6).
REQ-015 The block SHALL have port state, output, 2, FSM state: IDLE=00, CREDIT=01, VEND=10, CHANGE=11.

Function
REQ-016 Each of coin50, coin100, buy and cancel SHALL be registered once; an event SHALL occur when the input is sampled 1 and its register holds 0, and SHALL act at that same clock edge.
REQ-017 Coin events SHALL be accepted only in IDLE or CREDIT; coin events in VEND or CHANGE SHALL leave credit unchanged and pulse coin_reject.
REQ-018 An accepted coin that would raise credit above 6 SHALL leave credit unchanged and pulse coin_reject.
REQ-019 Simultaneous coin50 and coin100 events SHALL add 3 if the result is at most 6; otherwise both coins SHALL be rejected with one coin_reject pulse.
REQ-020 IDLE SHALL move to CREDIT at the edge where credit first becomes nonzero.
REQ-021 A buy event in CREDIT SHALL latch price_sel; if credit is at least the price, credit SHALL be reduced by the price and the FSM SHALL enter VEND with disp_req=1 at that same edge.
REQ-022 A buy event with insufficient credit SHALL pulse low_credit and leave the state unchanged.
REQ-023 A buy event in IDLE, VEND or CHANGE SHALL be ignored.
REQ-024 In VEND, disp_req SHALL stay 1 until disp_ack is sampled 1; at that edge disp_req SHALL go 0 and the FSM SHALL enter CHANGE if credit>0, otherwise IDLE.
REQ-025 A cancel event in CREDIT SHALL enter CHANGE; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-026 Simultaneous buy and cancel events in CREDIT SHALL be resolved as cancel.
REQ-027 In CHANGE, change_pulse SHALL assert for one cycle every second cycle, starting on the first cycle in CHANGE, and credit SHALL decrement by 1 with each pulse.
REQ-028 CHANGE SHALL go to IDLE at the edge where credit reaches 0, with no further pulse.
REQ-029 coin_reject and low_credit SHALL each be single-cycle pulses, and SHALL never be held high for longer than one cycle.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, credit=0, disp_req=0, change_pulse=0, coin_reject=0 and low_credit=0, clear the input registers and the timeout counter, and discard any in-progress vend or change without pulses.
REQ-031 An input held high through reset release SHALL produce no event until it goes low and rises again.

Configuration
REQ-032 With VEND_TIMEOUT_EN defined, CREDIT SHALL count cycles without any accepted coin or buy event, and reaching TIMEOUT_CYC SHALL enter CHANGE (full refund); the counter SHALL clear on every accepted coin, every buy and every state entry.
REQ-033 Without VEND_TIMEOUT_EN, CREDIT SHALL be held indefinitely and no counter logic SHALL exist.

Verification
REQ-034 Bench scenario: coin100, coin50, price_sel=01, buy -> credit 2, 3, then 0; disp_req=1; then disp_ack -> state IDLE with no change_pulse.
REQ-035 Bench scenario: four coin100 events, price_sel=00, buy, disp_ack -> credit capped at 6 with one coin_reject; after ack, four change_pulse pulses spaced 2 cycles apart, then IDLE.
REQ-036 Bench scenario: coin50, buy with price_sel=10 -> low_credit pulse, state remains CREDIT, credit 1.
REQ-037 Bench scenario: coin100, then buy and cancel on the same edge -> CHANGE, two change_pulse pulses, disp_req never 1.
REQ-038 Bench scenario: rst asserted mid-CHANGE with credit 3 -> outputs cleared asynchronously, no further change_pulse.
REQ-039 Bench scenario: with VEND_TIMEOUT_EN and TIMEOUT_CYC=10, coin50 then idle -> CHANGE entered 10 cycles after the coin, one change_pulse.
